// File: rtl/mem_read_responder_if.sv
// Request/response bundle between the memory mux (master) and the memory responder (slave).
interface mem_read_responder_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16
);
  logic              enable;
  logic              wr;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] data_in;
  logic [DWIDTH-1:0] data_out;
  logic              data_valid;
  logic [3:0]        outstanding;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, outstanding
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, outstanding
  );
endinterface

// File: rtl/mem_read_responder.sv
// Word-addressed memory responder: writes commit at issue, reads return in order LATENCY cycles later.
// Always ready; one request per cycle, no backpressure.
module mem_read_responder #(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 16,
  parameter int DEPTH_BITS = 15,
  parameter int LATENCY    = 4
) (
  input logic                 clk,
  input logic                 rst,
  mem_read_responder_if.slave bus
);
  localparam int WORDS = 1 << DEPTH_BITS;

  typedef struct packed {
    logic              vld;
    logic [DWIDTH-1:0] dat;
  } stage_t;

  logic [DWIDTH-1:0]     mem [WORDS];
  stage_t                pipe [LATENCY];
  logic [DEPTH_BITS-1:0] word_idx;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ret;
  logic [3:0]            outstanding_q;
  logic                  unused_addr;

  assign word_idx = bus.addr[DEPTH_BITS:1];
  assign rd_acc   = bus.enable & ~bus.wr;
  assign wr_acc   = bus.enable & bus.wr;
  assign ret      = pipe[LATENCY-1].vld;
  // addr[0] and any bits above the word index are deliberately ignored
  assign unused_addr = ^bus.addr;

  // Storage is never reset; only requests seen outside reset may write it.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[word_idx] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
      outstanding_q <= '0;
    end else begin
      // Invalid slots carry zero data so data_out is already 0 when data_valid is low.
      pipe[0].vld <= rd_acc;
      pipe[0].dat <= rd_acc ? mem[word_idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
      case ({rd_acc, ret})
        2'b10:   outstanding_q <= outstanding_q + 4'd1;
        2'b01:   outstanding_q <= outstanding_q - 4'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign bus.data_valid  = ret;
  assign bus.data_out    = pipe[LATENCY-1].dat;
  assign bus.outstanding = outstanding_q;
endmodule
